// File: rtl/if_fetch_stage_if.sv
// Bundle of the fetch stage's control inputs, instruction-memory port and IF/ID outputs.
// The master side belongs to the fetch stage; the slave side is the surrounding pipeline.
interface if_fetch_stage_if;
    logic        EN;
    logic        Stall;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic [31:0] Imem_Addr;
    logic [31:0] Imem_Data;
    logic [31:0] Addr;
    logic [31:0] Instr;
    logic        Valid;

    modport master (
        input  EN,
        input  Stall,
        input  Branch_Taken,
        input  Branch_Target,
        input  Imem_Data,
        output Imem_Addr,
        output Addr,
        output Instr,
        output Valid
    );

    modport slave (
        output EN,
        output Stall,
        output Branch_Taken,
        output Branch_Target,
        output Imem_Data,
        input  Imem_Addr,
        input  Addr,
        input  Instr,
        input  Valid
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, drives a 1-cycle-latency synchronous instruction memory
// and produces the IF/ID register (Addr, Instr, Valid) for decode.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic               CLK,
    input  logic               CLR,
    if_fetch_stage_if.master   bus
);

    logic [31:0] pc_q,       pc_d;
    logic [31:0] f2_pc_q,    f2_pc_d;
    logic        f2_valid_q, f2_valid_d;
    logic [31:0] addr_q,     addr_d;
    logic [31:0] instr_q,    instr_d;
    logic        valid_q,    valid_d;

    logic        hold;
    logic [31:0] target;

    assign hold   = bus.Stall | ~bus.EN;
    assign target = bus.Branch_Target & 32'hFFFF_FFFC;

    // While held, re-present f2_pc so next cycle's Imem_Data still belongs to it.
    always_comb begin
        if (bus.Branch_Taken) begin
            bus.Imem_Addr = target;
        end else if (hold) begin
            bus.Imem_Addr = f2_pc_q;
        end else begin
            bus.Imem_Addr = pc_q;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        f2_pc_d    = f2_pc_q;
        f2_valid_d = f2_valid_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        valid_d    = valid_q;

        if (bus.Branch_Taken) begin
            // The in-flight f2 fetch is dropped; the target fetch is already on the bus.
            valid_d    = 1'b0;
            instr_d    = NOP_INSTR;
            f2_pc_d    = target;
            f2_valid_d = 1'b1;
            pc_d       = target + 32'd4;
        end else if (!hold) begin
            addr_d     = f2_pc_q;
            instr_d    = f2_valid_q ? bus.Imem_Data : NOP_INSTR;
            valid_d    = f2_valid_q;
            f2_pc_d    = pc_q;
            f2_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            pc_q       <= RESET_PC;
            f2_pc_q    <= 32'd0;
            f2_valid_q <= 1'b0;
            addr_q     <= 32'd0;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            f2_pc_q    <= f2_pc_d;
            f2_valid_q <= f2_valid_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.Addr  = addr_q;
    assign bus.Instr = instr_q;
    assign bus.Valid = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios with literal expectations,
// then randomized control inputs checked every cycle against a behavioural model.
module tb_if_fetch_stage;

    logic clk = 1'b0;
    logic clr1;
    logic clr2 = 1'b1;

    always #5 clk = ~clk;

    if_fetch_stage_if f1 ();
    if_fetch_stage_if f2 ();

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut1 (
        .CLK (clk),
        .CLR (clr1),
        .bus (f1.master)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(32'h0000_0000)) dut2 (
        .CLK (clk),
        .CLR (clr2),
        .bus (f2.master)
    );

    // Memory: data reflects the address presented in the previous cycle.
    logic [31:0] prev1 = 32'd0;
    logic [31:0] prev2 = 32'd0;
    always @(posedge clk) begin
        prev1 <= f1.Imem_Addr;
        prev2 <= f2.Imem_Addr;
    end
    assign f1.Imem_Data = {16'hA5A5, prev1[15:0]};
    assign f2.Imem_Data = {16'hA5A5, prev2[15:0]};

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state: what the stage holds per the fetch rules.
    logic [31:0] m_pc, m_f2pc, m_addr;
    logic        m_f2v, m_valid;
    bit          m_known = 1'b0;
    logic [31:0] seen_imem;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hA5A5, a[15:0]};
    endfunction

    task automatic compare_outputs();
        chk("model_valid", {31'd0, f1.Valid}, {31'd0, m_valid});
        chk("model_addr",  f1.Addr, m_addr);
        chk("model_instr", f1.Instr, m_valid ? mem_word(m_addr) : 32'd0);
    endtask

    task automatic tick(input bit c, input bit en, input bit st, input bit bt, input logic [31:0] tgt);
        logic [31:0] t;
        logic [31:0] exp_imem;
        @(negedge clk);
        clr1 = c;
        f1.EN = en;
        f1.Stall = st;
        f1.Branch_Taken = bt;
        f1.Branch_Target = tgt;
        #1;
        seen_imem = f1.Imem_Addr;
        t = {tgt[31:2], 2'b00};
        if (m_known) begin
            exp_imem = bt ? t : ((!en || st) ? m_f2pc : m_pc);
            chk("model_imem_addr", seen_imem, exp_imem);
        end
        @(posedge clk);
        if (c) begin
            m_pc = 32'h0; m_f2pc = 32'h0; m_f2v = 1'b0; m_addr = 32'h0; m_valid = 1'b0;
            m_known = 1'b1;
        end else if (bt) begin
            m_valid = 1'b0; m_f2pc = t; m_f2v = 1'b1; m_pc = t + 32'd4;
        end else if (en && !st) begin
            m_addr = m_f2pc; m_valid = m_f2v; m_f2pc = m_pc; m_f2v = 1'b1; m_pc = m_pc + 32'd4;
        end
        #1;
        if (m_known) compare_outputs();
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) tick(0, 1, 0, 0, 32'h0);
    endtask

    initial begin
        clr1 = 1'b1;
        f1.EN = 1'b1; f1.Stall = 1'b0; f1.Branch_Taken = 1'b0; f1.Branch_Target = 32'h0;
        f2.EN = 1'b1; f2.Stall = 1'b0; f2.Branch_Taken = 1'b0; f2.Branch_Target = 32'h0;

        // Scenario 1: reset then free-run
        tick(1, 1, 0, 0, 32'h0);
        chk("s1_reset_valid", {31'd0, f1.Valid}, 32'd0);
        chk("s1_reset_instr", f1.Instr, 32'h0);
        tick(0, 1, 0, 0, 32'h0);
        chk("s1_first_imem", seen_imem, 32'h0);
        chk("s1_edge1_valid", {31'd0, f1.Valid}, 32'd0);
        tick(0, 1, 0, 0, 32'h0);
        chk("s1_edge1_imem", seen_imem, 32'h4);
        chk("s1_addr0", f1.Addr, 32'h0);
        chk("s1_instr0", f1.Instr, 32'hA5A5_0000);
        chk("s1_valid0", {31'd0, f1.Valid}, 32'd1);
        tick(0, 1, 0, 0, 32'h0);
        chk("s1_addr4", f1.Addr, 32'h4);
        chk("s1_instr4", f1.Instr, 32'hA5A5_0004);
        tick(0, 1, 0, 0, 32'h0);
        chk("s1_addr8", f1.Addr, 32'h8);

        // Scenario 2: stall three cycles at Addr=8
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 1, 0, 32'h0);
            chk("s2_replay_imem", seen_imem, 32'hC);
            chk("s2_hold_addr", f1.Addr, 32'h8);
            chk("s2_hold_instr", f1.Instr, 32'hA5A5_0008);
        end
        tick(0, 1, 0, 0, 32'h0);
        chk("s2_rel_addr", f1.Addr, 32'hC);
        chk("s2_rel_instr", f1.Instr, 32'hA5A5_000C);
        tick(0, 1, 0, 0, 32'h0);
        chk("s2_rel_addr2", f1.Addr, 32'h10);
        chk("s2_rel_instr2", f1.Instr, 32'hA5A5_0010);

        // Scenario 3: branch to 0x40 with IF/ID at Addr=8
        tick(1, 1, 0, 0, 32'h0);
        run_n(4);
        chk("s3_pre_addr", f1.Addr, 32'h8);
        tick(0, 1, 0, 1, 32'h40);
        chk("s3_br_imem", seen_imem, 32'h40);
        chk("s3_br_valid", {31'd0, f1.Valid}, 32'd0);
        chk("s3_br_instr", f1.Instr, 32'h0);
        chk("s3_br_addr_kept", f1.Addr, 32'h8);
        tick(0, 1, 0, 0, 32'h0);
        chk("s3_tgt_addr", f1.Addr, 32'h40);
        chk("s3_tgt_instr", f1.Instr, 32'hA5A5_0040);
        tick(0, 1, 0, 0, 32'h0);
        chk("s3_next_addr", f1.Addr, 32'h44);

        // Scenario 4: branch wins over stall, unaligned target
        tick(0, 1, 1, 1, 32'h103);
        chk("s4_br_imem", seen_imem, 32'h100);
        chk("s4_br_valid", {31'd0, f1.Valid}, 32'd0);
        tick(0, 1, 0, 0, 32'h0);
        chk("s4_tgt_addr", f1.Addr, 32'h100);
        chk("s4_tgt_instr", f1.Instr, 32'hA5A5_0100);
        // EN=0 behaves as a hold
        tick(0, 0, 0, 0, 32'h0);
        chk("s4_en0_addr", f1.Addr, 32'h100);

        // Scenario 5: wrap-around on the second instance
        clr2 = 1'b1;
        tick(0, 1, 0, 0, 32'h0);
        clr2 = 1'b0;
        tick(0, 1, 0, 0, 32'h0);
        chk("s5_edge1_valid", {31'd0, f2.Valid}, 32'd0);
        tick(0, 1, 0, 0, 32'h0);
        chk("s5_addr_fff8", f2.Addr, 32'hFFFF_FFF8);
        chk("s5_instr_fff8", f2.Instr, 32'hA5A5_FFF8);
        tick(0, 1, 0, 0, 32'h0);
        chk("s5_addr_fffc", f2.Addr, 32'hFFFF_FFFC);
        tick(0, 1, 0, 0, 32'h0);
        chk("s5_addr_wrap", f2.Addr, 32'h0);
        chk("s5_instr_wrap", f2.Instr, 32'hA5A5_0000);

        // Scenario 6: reset during stall and pending branch
        tick(0, 1, 1, 0, 32'h0);
        tick(1, 1, 1, 1, 32'h200);
        chk("s6_valid", {31'd0, f1.Valid}, 32'd0);
        chk("s6_instr", f1.Instr, 32'h0);
        tick(0, 1, 0, 0, 32'h0);
        chk("s6_pc_reset", seen_imem, 32'h0);
        chk("s6_edge1_valid", {31'd0, f1.Valid}, 32'd0);
        tick(0, 1, 0, 0, 32'h0);
        chk("s6_addr0", f1.Addr, 32'h0);
        chk("s6_instr0", f1.Instr, 32'hA5A5_0000);
        tick(0, 1, 0, 0, 32'h0);
        chk("s6_addr4", f1.Addr, 32'h4);

        // Randomized control traffic against the model
        for (int i = 0; i < 2000; i++) begin
            bit c, en, st, bt;
            logic [31:0] tgt;
            c   = ($urandom_range(0, 99) < 2);
            en  = ($urandom_range(0, 99) >= 10);
            st  = ($urandom_range(0, 99) < 20);
            bt  = ($urandom_range(0, 99) < 12);
            tgt = $urandom;
            tick(c, en, st, bt, tgt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
